// File: rtl/servo_pwm_gen.sv
// Two-channel servo PWM generator: latches clamped pan/tilt commands, slews the
// active commands once per frame and emits frame-aligned pulses plus a settled flag.
`timescale 1ns/1ps
module servo_pwm_gen #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int PERIOD_US = 20000,
  parameter int BASE_US   = 1000,
  parameter int CMD_MAX   = 1000,
  parameter int CENTER    = 500,
  parameter int SLEW_STEP = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] pan,
  input  logic [10:0] tilt,
  input  logic        cmd_valid,
  output logic        pwm_pan,
  output logic        pwm_tilt,
  output logic        frame_strobe,
  output logic        settled
);

  localparam int DIV = CLK_HZ / 1_000_000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW  = $clog2(PERIOD_US);

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(PERIOD_US - 1);
  localparam logic [10:0]   CMD_MAX_C  = 11'(CMD_MAX);
  localparam logic [10:0]   CENTER_C   = 11'(CENTER);
  localparam logic [10:0]   SLEW_C     = 11'(SLEW_STEP);
  localparam logic [FW:0]   BASE_C     = (FW+1)'(BASE_US);

  logic [PW-1:0] r_presc;
  logic [FW-1:0] r_frame_cnt;
  logic [10:0]   r_tgt_pan, r_tgt_tilt;
  logic [10:0]   r_act_pan, r_act_tilt;
  logic          r_pwm_pan, r_pwm_tilt, r_frame_strobe, r_settled;

  logic          w_us_tick, w_frame_start;
  logic [FW:0]   w_thr_pan, w_thr_tilt;

  function automatic logic [10:0] clamp_cmd(input logic [10:0] cmd);
    return (cmd > CMD_MAX_C) ? CMD_MAX_C : cmd;
  endfunction

  // Signed 12-bit difference so a target below the active value does not wrap.
  function automatic logic [10:0] slew_next(input logic [10:0] act, input logic [10:0] tgt);
    logic signed [11:0] d;
    logic signed [11:0] mag;
    d   = $signed({1'b0, tgt}) - $signed({1'b0, act});
    mag = (d < 0) ? -d : d;
    if (SLEW_STEP == 0 || mag <= $signed({1'b0, SLEW_C})) return tgt;
    else if (d > 0)                                       return act + SLEW_C;
    else                                                  return act - SLEW_C;
  endfunction

  assign w_us_tick     = (r_presc == PRESC_LAST);
  assign w_frame_start = w_us_tick && (r_frame_cnt == FRAME_LAST);
  assign w_thr_pan     = BASE_C + (FW+1)'(r_act_pan);
  assign w_thr_tilt    = BASE_C + (FW+1)'(r_act_tilt);

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // sample the pre-edge values of each other, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_presc <= w_us_tick ? '0 : r_presc + PW'(1);
      if (w_us_tick)
        r_frame_cnt <= (r_frame_cnt == FRAME_LAST) ? '0 : r_frame_cnt + FW'(1);
    end
  end

  // The slew step reads the pre-edge target, so a command landing on the
  // frame_start edge takes effect one frame later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tgt_pan  <= CENTER_C;
      r_tgt_tilt <= CENTER_C;
      r_act_pan  <= CENTER_C;
      r_act_tilt <= CENTER_C;
    end else begin
      if (cmd_valid) begin
        r_tgt_pan  <= clamp_cmd(pan);
        r_tgt_tilt <= clamp_cmd(tilt);
      end
      if (w_frame_start) begin
        r_act_pan  <= slew_next(r_act_pan, r_tgt_pan);
        r_act_tilt <= slew_next(r_act_tilt, r_tgt_tilt);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_pan      <= 1'b0;
      r_pwm_tilt     <= 1'b0;
      r_frame_strobe <= 1'b0;
      r_settled      <= 1'b1;
    end else begin
      r_pwm_pan      <= ({1'b0, r_frame_cnt} < w_thr_pan);
      r_pwm_tilt     <= ({1'b0, r_frame_cnt} < w_thr_tilt);
      r_frame_strobe <= w_frame_start;
      r_settled      <= (r_act_pan == r_tgt_pan) && (r_act_tilt == r_tgt_tilt);
    end
  end

  assign pwm_pan      = r_pwm_pan;
  assign pwm_tilt     = r_pwm_tilt;
  assign frame_strobe = r_frame_strobe;
  assign settled      = r_settled;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Self-checking bench for servo_pwm_gen: a slewing instance and an unlimited-slew
// instance share stimulus and are compared frame by frame against an arithmetic model.
`timescale 1ns/1ps
module tb_servo_pwm_gen;

  localparam int CLK_HZ    = 4_000_000;
  localparam int PERIOD_US = 200;
  localparam int BASE_US   = 20;
  localparam int CMD_MAX   = 100;
  localparam int CENTER    = 50;
  localparam int CYC       = CLK_HZ / 1_000_000;
  localparam int FRAME     = PERIOD_US * CYC;

  logic        clk;
  logic        rst_n;
  logic [10:0] pan, tilt;
  logic        cmd_valid;
  logic [1:0]  pwm_pan_w, pwm_tilt_w, frame_strobe_w, settled_w;

  int n_checks = 0;
  int n_errors = 0;
  int n_frame  = 0;

  // Model state, index [dut][channel]; dut 0 slews by 10, dut 1 is unlimited.
  int m_act [2][2];
  int m_tgt [2][2];
  int m_slew [2] = '{10, 0};
  bit m_pend;
  int m_pend_p, m_pend_t;

  servo_pwm_gen #(.CLK_HZ(CLK_HZ), .PERIOD_US(PERIOD_US), .BASE_US(BASE_US),
                  .CMD_MAX(CMD_MAX), .CENTER(CENTER), .SLEW_STEP(10)) dut (
    .clk(clk), .rst_n(rst_n), .pan(pan), .tilt(tilt), .cmd_valid(cmd_valid),
    .pwm_pan(pwm_pan_w[0]), .pwm_tilt(pwm_tilt_w[0]),
    .frame_strobe(frame_strobe_w[0]), .settled(settled_w[0]));

  servo_pwm_gen #(.CLK_HZ(CLK_HZ), .PERIOD_US(PERIOD_US), .BASE_US(BASE_US),
                  .CMD_MAX(CMD_MAX), .CENTER(CENTER), .SLEW_STEP(0)) dut_noslew (
    .clk(clk), .rst_n(rst_n), .pan(pan), .tilt(tilt), .cmd_valid(cmd_valid),
    .pwm_pan(pwm_pan_w[1]), .pwm_tilt(pwm_tilt_w[1]),
    .frame_strobe(frame_strobe_w[1]), .settled(settled_w[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clamp(int c);
    return (c > CMD_MAX) ? CMD_MAX : c;
  endfunction

  function automatic int step_toward(int a, int t, int s);
    int d;
    d = t - a;
    if (s == 0 || (d < 0 ? -d : d) <= s) return t;
    return (d > 0) ? a + s : a - s;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        m_act[d][c] = CENTER;
        m_tgt[d][c] = CENTER;
      end
    m_pend = 1'b0;
  endtask

  task automatic set_tgt(int p, int t);
    for (int d = 0; d < 2; d++) begin
      m_tgt[d][0] = clamp(p);
      m_tgt[d][1] = clamp(t);
    end
  endtask

  // One frame boundary: move toward the old target, then apply a command
  // that arrived exactly on the boundary edge.
  task automatic model_frame();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++)
        m_act[d][c] = step_toward(m_act[d][c], m_tgt[d][c], m_slew[d]);
    if (m_pend) begin
      set_tgt(m_pend_p, m_pend_t);
      m_pend = 1'b0;
    end
  endtask

  // Sample index i is the cycle after the i-th edge of the frame (i=0 is the
  // frame_strobe cycle). Expect pwm high for 1 <= i <= width.
  task automatic measure(input int start_i, input int inj_at, input int ip, input int it);
    int  w [2][2];
    int  hi [2][2];
    int  bad [2][2];
    int  strobe_bad;
    logic obs;
    bit  exp_set;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        w[d][c]   = (BASE_US + m_act[d][c]) * CYC;
        hi[d][c]  = 0;
        bad[d][c] = 0;
      end
    strobe_bad = 0;
    for (int i = start_i; i < FRAME; i++) begin
      if (i == inj_at) begin
        pan       = 11'(ip);
        tilt      = 11'(it);
        cmd_valid = 1'b1;
        if (inj_at == FRAME - 1) begin
          m_pend   = 1'b1;
          m_pend_p = ip;
          m_pend_t = it;
        end else
          set_tgt(ip, it);
      end
      if (frame_strobe_w !== {2{i == 0}}) strobe_bad++;
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < 2; c++) begin
          obs = (c == 0) ? pwm_pan_w[d] : pwm_tilt_w[d];
          if (obs === 1'b1) hi[d][c]++;
          if (obs !== ((i >= 1) && (i <= w[d][c]))) bad[d][c]++;
        end
      if (i == 2 || (inj_at >= 0 && i == inj_at + 2)) begin
        for (int d = 0; d < 2; d++) begin
          exp_set = (m_act[d][0] == m_tgt[d][0]) && (m_act[d][1] == m_tgt[d][1]);
          n_checks++;
          if (settled_w[d] !== exp_set) begin
            n_errors++;
            $display("FAIL frame%0d dut%0d settled@%0d: got %b required %b",
                     n_frame, d, i, settled_w[d], exp_set);
          end
        end
      end
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    n_checks++;
    if (strobe_bad !== 0) begin
      n_errors++;
      $display("FAIL frame%0d strobe_timing: %0d wrong samples, required 0", n_frame, strobe_bad);
    end
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        n_checks++;
        if (bad[d][c] !== 0) begin
          n_errors++;
          $display("FAIL frame%0d dut%0d %s width: got %0d cycles (%0d bad samples) required %0d",
                   n_frame, d, (c == 0) ? "pan" : "tilt", hi[d][c], bad[d][c], w[d][c]);
        end
      end
    n_frame++;
  endtask

  task automatic run_frame(input int inj_at, input int ip, input int it);
    model_frame();
    measure(0, inj_at, ip, it);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({pwm_pan_w, pwm_tilt_w, frame_strobe_w, settled_w} !== 8'b0000_0011) begin
      n_errors++;
      $display("FAIL reset_values: got %b required 00000011",
               {pwm_pan_w, pwm_tilt_w, frame_strobe_w, settled_w});
    end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    measure(1, -1, 0, 0);
    run_frame(-1, 0, 0);
  endtask

  task automatic test_slew();
    run_frame(400, 80, 30);
    repeat (4) run_frame(-1, 0, 0);
  endtask

  task automatic test_clamp();
    run_frame(123, 2000, 1500);
    repeat (8) run_frame(-1, 0, 0);
  endtask

  task automatic test_coincident();
    run_frame(200, 50, 50);
    repeat (5) run_frame(-1, 0, 0);
    run_frame(FRAME - 1, 60, 50);
    repeat (2) run_frame(-1, 0, 0);
  endtask

  task automatic test_slew_zero();
    run_frame(300, 0, 100);
    repeat (2) run_frame(-1, 0, 0);
  endtask

  task automatic test_random();
    int p, t, k, n;
    for (int r = 0; r < 6; r++) begin
      p = int'($urandom_range(0, 2047));
      t = int'($urandom_range(0, 2047));
      k = ($urandom_range(0, 3) == 0) ? FRAME - 1 : int'($urandom_range(10, 790));
      n = int'($urandom_range(1, 3));
      run_frame(k, p, t);
      repeat (n) run_frame(-1, 0, 0);
    end
  endtask

  task automatic test_reset_mid();
    repeat (50) @(negedge clk);
    n_checks++;
    if ({pwm_pan_w, pwm_tilt_w} !== 4'b1111) begin
      n_errors++;
      $display("FAIL mid_pulse_before_reset: got %b required 1111", {pwm_pan_w, pwm_tilt_w});
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pwm_pan_w, pwm_tilt_w, frame_strobe_w, settled_w} !== 8'b0000_0011) begin
      n_errors++;
      $display("FAIL async_reset_drop: got %b required 00000011",
               {pwm_pan_w, pwm_tilt_w, frame_strobe_w, settled_w});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    measure(1, -1, 0, 0);
    run_frame(-1, 0, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    pan       = '0;
    tilt      = '0;
    cmd_valid = 1'b0;
    test_reset();
    test_slew();
    test_clamp();
    test_coincident();
    test_slew_zero();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
